// File: rtl/axi4_bridge_pkg.sv
// Shared definitions for the bridge's AXI4 slave endpoints: response codes,
// burst codes and the read-channel state encoding.
package axi4_bridge_pkg;

   localparam logic [1:0] AXI_RESP_OK     = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FETCH = 2'd1,
      RD_DATA  = 2'd2
   } rd_state_e;

endpackage

// File: rtl/axi4_s_r_if.sv
// AXI4 read address and read data channels between an HDL master and the
// bridge's slave read endpoint.
interface axi4_s_r_if #(
   parameter int TAGW = 3,
   parameter int ADRW = 64,
   parameter int DATW = 512
);
   logic [TAGW-1:0] arid;
   logic [ADRW-1:0] araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic [3:0]      arregion;
   logic            arvalid;
   logic            arready;

   logic [TAGW-1:0] rid;
   logic [DATW-1:0] rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arregion, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arregion, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/axi4_s_r.sv
// AXI4 slave read endpoint: one AR at a time, whole burst fetched from the
// host side in a single request into a local buffer, then streamed as R beats.
module axi4_s_r
   import axi4_bridge_pkg::*;
#(
   parameter int TAGW  = 3,
   parameter int ADRW  = 64,
   parameter int DATW  = 512,
   parameter int STBW  = DATW / 8,
   parameter int DTMP  = 4096,
   parameter int NBEAT = DTMP / STBW,
   parameter int RLAT  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   axi4_s_r_if.slave         s,
   // Host fetch port: the host answers a request in the same cycle, the way
   // the QEMU read call fills the byte buffer before returning.
   output logic              o_h_req,
   output logic [ADRW-1:0]   o_h_addr,
   output logic [2:0]        o_h_width,
   output logic [7:0]        o_h_len,
   input  logic [31:0]       i_h_status,
   input  logic [DTMP*8-1:0] i_h_buf
);

   localparam int BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

   rd_state_e       state_q;
   logic            arready_q;
   logic            rvalid_q;
   logic            rlast_q;
   logic [TAGW-1:0] id_q;
   logic [TAGW-1:0] rid_q;
   logic [1:0]      rresp_q;
   logic [DATW-1:0] rdata_q;
   logic [7:0]      len_q;
   logic [7:0]      beat_q;
   logic [7:0]      cnt_q;
   logic            err_q;
   logic            ovs_q;
   logic [DATW-1:0] buf_q [NBEAT];

   logic            ar_hs;
   logic            ovs_d;
   logic [7:0]      beat_d;
   logic [7:0]      beat_sel;
   logic [DATW-1:0] beat_data;

   assign ar_hs = s.arvalid && arready_q;
   assign ovs_d = (int'(s.arlen) + 1) > NBEAT;

   assign o_h_req   = i_rst_n && ar_hs && !ovs_d;
   assign o_h_addr  = s.araddr;
   assign o_h_width = s.arsize;
   assign o_h_len   = s.arlen;

   // One fetch per accepted request; an oversize burst never reaches the host.
   always_ff @(posedge i_clk) begin
      if (o_h_req) begin
         for (int b = 0; b < NBEAT; b++) begin
            buf_q[b] <= i_h_buf[b*DATW +: DATW];
         end
      end
      if (i_rst_n && ar_hs) begin
         ovs_q <= ovs_d;
         err_q <= ovs_d || (i_h_status != 32'd0);
      end
   end

   assign beat_d    = beat_q + 8'd1;
   assign beat_sel  = (state_q == RD_FETCH) ? 8'd0 : beat_d;
   assign beat_data = ovs_q ? '0 : buf_q[beat_sel[BW-1:0]];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= RD_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= AXI_RESP_OK;
         rdata_q   <= '0;
         id_q      <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (ar_hs) begin
                  id_q      <= s.arid;
                  len_q     <= s.arlen;
                  cnt_q     <= 8'(RLAT);
                  arready_q <= 1'b0;
                  state_q   <= RD_FETCH;
               end
            end
            RD_FETCH: begin
               if (cnt_q == 8'd0) begin
                  state_q  <= RD_DATA;
                  beat_q   <= 8'd0;
                  rvalid_q <= 1'b1;
                  rid_q    <= id_q;
                  rresp_q  <= err_q ? AXI_RESP_SLVERR : AXI_RESP_OK;
                  rlast_q  <= (len_q == 8'd0);
                  rdata_q  <= beat_data;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RD_DATA: begin
               if (s.rready && rvalid_q) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     state_q   <= RD_IDLE;
                  end else begin
                     beat_q  <= beat_d;
                     rdata_q <= beat_data;
                     rlast_q <= (beat_d == len_q);
                  end
               end
            end
            default: state_q <= RD_IDLE;
         endcase
      end
   end

   assign s.arready = arready_q;
   assign s.rvalid  = rvalid_q;
   assign s.rlast   = rlast_q;
   assign s.rid     = rid_q;
   assign s.rresp   = rresp_q;
   assign s.rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_s_r.sv
// Directed bench for axi4_s_r: table of bursts plus reset-abort and
// back-to-back AR sequences, with a behavioural host answering fetches.
module tb_axi4_s_r;
   import axi4_bridge_pkg::*;

   localparam int TAGW = 3;
   localparam int ADRW = 64;
   localparam int DATW = 512;
   localparam int STBW = DATW / 8;
   localparam int DTMP = 4096;

   typedef struct {
      logic [TAGW-1:0] id;
      logic [ADRW-1:0] addr;
      logic [7:0]      len;
      logic [2:0]      size;
      logic [7:0]      seed;
      int              status;
      bit              bp;
      logic [1:0]      resp;
      int              nreq;
      bit              zero;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic              h_req;
   logic [ADRW-1:0]   h_addr;
   logic [2:0]        h_width;
   logic [7:0]        h_len;
   logic [31:0]       h_status;
   logic [DTMP*8-1:0] h_buf;

   logic [7:0]      m_seed = 8'd0;
   int              m_status = 0;
   logic [ADRW-1:0] m_addr = '0;
   logic [2:0]      m_size = '0;
   logic [7:0]      m_len = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int req_cnt = 0;

   axi4_s_r_if #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW)) bus ();

   axi4_s_r dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .s          (bus.slave),
      .o_h_req    (h_req),
      .o_h_addr   (h_addr),
      .o_h_width  (h_width),
      .o_h_len    (h_len),
      .i_h_status (h_status),
      .i_h_buf    (h_buf)
   );

   always #5 clk = ~clk;

   // Host memory: byte at offset i of the burst reads as (i + seed).
   always_comb begin
      h_buf = '0;
      for (int i = 0; i < DTMP; i++) h_buf[i*8 +: 8] = 8'(i) + m_seed;
      h_status = 32'(m_status);
   end

   always @(negedge clk) begin
      if (h_req) begin
         req_cnt++;
         n_cmp++;
         if ({h_addr, h_width, h_len} !== {m_addr, m_size, m_len}) begin
            n_bad++;
            $display("FAIL host_req_args: got addr=%h w=%0d len=%0d want addr=%h w=%0d len=%0d",
                     h_addr, h_width, h_len, m_addr, m_size, m_len);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [DATW-1:0] got, input logic [DATW-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [DATW-1:0] exp_beat(input int k, input logic [7:0] seed, input bit zero);
      logic [DATW-1:0] r;
      r = '0;
      if (!zero) for (int j = 0; j < STBW; j++) r[j*8 +: 8] = 8'(k*STBW + j) + seed;
      return r;
   endfunction

   task automatic drive_ar(input vec_t v);
      bus.arid    = v.id;
      bus.araddr  = v.addr;
      bus.arlen   = v.len;
      bus.arsize  = v.size;
      bus.arvalid = 1'b1;
      m_seed   = v.seed;
      m_status = v.status;
      m_addr   = v.addr;
      m_size   = v.size;
      m_len    = v.len;
   endtask

   task automatic send_ar(input vec_t v);
      int g;
      g = 0;
      while (!bus.arready && g < 50) begin
         tick();
         g++;
      end
      check("arready_before_ar", DATW'(bus.arready), DATW'(1'b1));
      drive_ar(v);
   endtask

   // Called in the cycle where the AR handshake takes place.
   task automatic run_burst(input vec_t v, input int abort_at, input bit has_next, input vec_t nxt);
      int lat, k, c, guard, req0;
      bit rdy;
      req0 = req_cnt;
      tick();
      if (has_next) drive_ar(nxt);
      else bus.arvalid = 1'b0;
      lat = 1;
      while (!bus.rvalid && lat < 20) begin
         tick();
         lat++;
      end
      check("first_beat_latency", DATW'(lat), DATW'(4));
      k = 0;
      c = 0;
      guard = 0;
      while (k <= int'(v.len) && guard < 400) begin
         rdy = v.bp ? (c % 3 == 0) : 1'b1;
         check($sformatf("beat%0d_ctrl", k),
               DATW'({bus.rvalid, bus.rid, bus.rresp, bus.rlast, bus.arready}),
               DATW'({1'b1, v.id, v.resp, (k == int'(v.len)), 1'b0}));
         check($sformatf("beat%0d_data", k), bus.rdata, exp_beat(k, v.seed, v.zero));
         if (k == abort_at) begin
            rst_n = 1'b0;
            drive_ar(v);
            tick();
            check("reset_abort_state", DATW'({bus.rvalid, bus.rlast, bus.arready}), DATW'(3'b001));
            check("reset_abort_reqs", DATW'(req_cnt - req0), DATW'(1));
            bus.arvalid = 1'b0;
            rst_n = 1'b1;
            tick();
            return;
         end
         bus.rready = rdy;
         tick();
         if (rdy) k++;
         c++;
         guard++;
      end
      bus.rready = 1'b0;
      check("burst_end_state", DATW'({bus.rvalid, bus.rlast, bus.arready}), DATW'(3'b001));
      check("burst_req_count", DATW'(req_cnt - req0), DATW'(v.nreq));
   endtask

   vec_t tbl [5];
   vec_t rv, pv, va, vb;

   initial begin
      //        id    addr           len    size  seed   st bp resp             nreq zero
      tbl[0] = '{3'd5, 64'h1000,     8'd0,  3'd6, 8'h00, 0, 0, AXI_RESP_OK,     1, 0};
      tbl[1] = '{3'd2, 64'h2000,     8'd3,  3'd6, 8'h00, 0, 0, AXI_RESP_OK,     1, 0};
      tbl[2] = '{3'd3, 64'h2000,     8'd3,  3'd6, 8'h00, 0, 1, AXI_RESP_OK,     1, 0};
      tbl[3] = '{3'd6, 64'h3000,     8'd1,  3'd6, 8'h11, 1, 0, AXI_RESP_SLVERR, 1, 0};
      tbl[4] = '{3'd7, 64'h4000,     8'd64, 3'd6, 8'h22, 0, 0, AXI_RESP_SLVERR, 0, 1};
      rv     = '{3'd4, 64'h5000,     8'd7,  3'd6, 8'h33, 0, 0, AXI_RESP_OK,     1, 0};
      pv     = '{3'd1, 64'h6000,     8'd2,  3'd6, 8'h44, 0, 0, AXI_RESP_OK,     1, 0};
      va     = '{3'd1, 64'h7000,     8'd1,  3'd6, 8'h55, 0, 1, AXI_RESP_OK,     1, 0};
      vb     = '{3'd6, 64'h8000,     8'd2,  3'd5, 8'h66, 0, 0, AXI_RESP_OK,     1, 0};

      rst_n = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = AXI_BURST_INCR; bus.arlock = 1'b0; bus.arcache = '0;
      bus.arprot = '0; bus.arregion = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (3) tick();
      check("reset_ctrl", DATW'({bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rresp}),
            DATW'({1'b1, 1'b0, 1'b0, 3'd0, 2'b00}));
      check("reset_rdata", bus.rdata, '0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         send_ar(tbl[i]);
         run_burst(tbl[i], -1, 1'b0, tbl[i]);
         $display("burst %0d id=%0d len=%0d done, compared=%0d", i, tbl[i].id, tbl[i].len, n_cmp);
      end

      send_ar(rv);
      run_burst(rv, 2, 1'b0, rv);
      $display("reset mid-burst sequence done, compared=%0d", n_cmp);
      send_ar(pv);
      run_burst(pv, -1, 1'b0, pv);
      $display("post-reset burst done, compared=%0d", n_cmp);

      send_ar(va);
      run_burst(va, -1, 1'b1, vb);
      run_burst(vb, -1, 1'b0, vb);
      $display("back-to-back bursts done, compared=%0d", n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi4_s_r.md
# axi4_s_r

AXI4 slave read-channel endpoint of the QEMU PCIe bridge. It accepts one AR request at a time and fetches the whole burst from QEMU with a single DPI-C call into a local byte buffer. It then returns the data as R beats with RLAST, honouring RREADY backpressure. It is the read-direction counterpart of the bridge's slave write endpoint and sits on the same HDL-side AXI4 slave port.

## Interface
- TAGW, 3, AXI ID width
- ADRW, 64, address width
- DATW, 512, data width in bits
- STBW, DATW/8, bytes per beat
- DTMP, 4096, burst buffer size in bytes
- NBEAT, DTMP/STBW, maximum beats per burst
- RLAT, 2, extra fetch-wait cycles modelling read latency (0..255)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low; clock i_clk
- i_s_arid  in  TAGW  read ID
- i_s_araddr  in  ADRW  start address
- i_s_arlen  in  8  beats minus one
- i_s_arsize  in  3  log2 bytes per beat, passed to QEMU as width
- i_s_arburst, i_s_arlock, i_s_arcache, i_s_arprot, i_s_arregion  in  2/1/4/3/4  accepted and ignored; only INCR is supported
- i_s_arvalid  in  1  AR valid
- o_s_arready  out  1  AR ready
- o_s_rid  out  TAGW  read ID
- o_s_rdata  out  DATW  read data
- o_s_rresp  out  2  response (00 OKAY, 10 SLVERR)
- o_s_rlast  out  1  last beat
- o_s_rvalid  out  1  R valid
- i_s_rready  in  1  R ready
- DPI import: int C_req_read(longint addr, int width, int len, output byte data_tmp[DTMP]). It returns 0 on success and non-zero on error.

## Operation
- States are RD_IDLE, RD_FETCH and RD_DATA. Every output is registered.
- **RD_IDLE**: o_s_arready=1. On i_s_arvalid&&o_s_arready:
  - Latch the ID, address, size and len, and set o_s_arready to 0 on the next edge.
  - Load the fetch counter with RLAT and go to RD_FETCH.
  - On that same edge, call C_req_read(addr, size, len, buf) exactly once and store the returned status.
- **Oversize request** (len+1 > NBEAT): the DPI call is skipped. The status is forced to error and the buffer is treated as zero.
- **RD_FETCH**: decrement the counter each cycle. When the counter is 0, go to RD_DATA and present beat 0:
  - o_s_rvalid=1 and o_s_rid=latched ID.
  - o_s_rresp = SLVERR if the status is non-zero, else OKAY.
  - o_s_rlast = (len==0).
- **Beat k data**: o_s_rdata[j*8+:8] = buf[k*STBW+j] for j in 0..STBW-1. Oversize requests return all-zero data.
- **RD_DATA**: on i_s_rready&&o_s_rvalid:
  - If the current beat is not last, advance the beat counter and present beat k+1 on the next cycle, with o_s_rlast=(k+1==len).
  - If the current beat is last, deassert o_s_rvalid and o_s_rlast, set o_s_arready=1 and return to RD_IDLE.
- Beat counter width is 8 bits and it never wraps, because the last beat is at most len=255.
- RRESP is the same on every beat of a burst.

## Timing
- **Reset values**: o_s_arready=1; o_s_rvalid=0, o_s_rlast=0, o_s_rid=0, o_s_rdata=0, o_s_rresp=OKAY. State is RD_IDLE.
- **First-beat latency**: if the AR handshake occurs in cycle n, RD_FETCH spans cycles n+1..n+1+RLAT. The first o_s_rvalid is in cycle n+2+RLAT (n+4 with the default RLAT).
- **Throughput**: with i_s_rready held at 1, one beat is transferred per cycle. A burst of len+1 beats holds o_s_rvalid for len+1 consecutive cycles.
- **Backpressure**: while o_s_rvalid=1 and i_s_rready=0, o_s_rdata, o_s_rid, o_s_rresp and o_s_rlast hold stable.
- **Back-to-back requests**: o_s_arready rises in the cycle after the last beat handshake. There is no outstanding-read overlap; i_s_arvalid held during a burst waits.
- **RVALID does not depend on RREADY**. ARREADY is asserted in RD_IDLE without waiting for ARVALID.
- **Reset mid-burst**: return to the reset values on the next edge and issue no further DPI calls. The partial burst is dropped.

## Structure
- Shared package axi4_bridge_pkg holds:
  - AXI_RESP_OK/AXI_RESP_SLVERR.
  - AXI burst codes.
  - The read-state enum {RD_IDLE, RD_FETCH, RD_DATA}, reused by the write endpoint's state constants.
- No sub-module: the byte buffer, beat mux and counters are inline. The DPI call lives in its own clocked block, gated by the AR handshake.

## Test plan
- **Single beat**: reset, AR id=5, addr=0x1000, len=0, size=6; DPI returns bytes 0x00..0x3F, status 0 -> one beat in cycle n+4 with rdata byte j = j, rid=5, rresp=00, rlast=1; arready=1 the next cycle.
- **4-beat burst, rready=1**: len=3, buffer byte i = i&0xFF -> four consecutive beats, beat k byte j = (64k+j)&0xFF, rlast only on beat 3.
- **Backpressure**: same 4-beat burst, rready toggling 1,0,0,1,… -> beat data/rlast stable during stalls, beats not skipped or repeated, exactly 4 handshakes.
- **Error and oversize**: DPI status 1 with len=1 -> both beats rresp=10. Then len=64 with DTMP=4096 -> no DPI call, 65 beats of zeros, all SLVERR.
- **Reset mid-burst**: assert i_rst_n=0 during beat 2 of 8 -> next cycle rvalid=0, arready=1. A new AR afterwards completes normally.
- **Back-to-back ARs**: arvalid held high over two requests -> second accepted only after the first rlast handshake, exactly one DPI call per request.
